hazard_forward_ctrl: RTL and testbench

HAZARD_FORWARD_CTRL -- requirements
Module: hazard_forward_ctrl

---
 rtl/hazard_forward_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller: shadow scoreboard of ID/EX, EX/MEM, MEM/WB with stall,
// flush and ALU-operand forwarding. Define HAZARD_FORWARD_EN to enable operand forwarding.
module hazard_forward_ctrl #(
   parameter int unsigned REG_AW = 5
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              ihit,
   input  logic              dhit,
   input  logic [REG_AW-1:0] rs_id,
   input  logic [REG_AW-1:0] rt_id,
   input  logic              dec_uses_rt,
   input  logic              dec_regwen,
   input  logic              dec_memread,
   input  logic              dec_memwrite,
   input  logic [REG_AW-1:0] dec_wsel,
   input  logic              branch_taken,
   output logic [1:0]        forwarda,
   output logic [1:0]        forwardb,
   output logic              pipe_adv,
   output logic              hz_stall,
   output logic              ifid_flush,
   output logic              idex_bubble
);

   logic              idex_valid_q, idex_regwen_q, idex_memread_q, idex_memwrite_q;
   logic [REG_AW-1:0] idex_wsel_q;
   logic              exmem_valid_q, exmem_regwen_q, exmem_memread_q, exmem_memwrite_q;
   logic [REG_AW-1:0] exmem_wsel_q;
   logic              memwb_valid_q, memwb_regwen_q;
   logic [REG_AW-1:0] memwb_wsel_q;

   logic rs_idex_hit, rt_idex_hit, rs_exmem_hit, rt_exmem_hit;
   logic hazard;

   // Register 0 is excluded from every match so it never forwards or stalls.
   assign rs_idex_hit  = idex_valid_q && (idex_wsel_q != '0) && (idex_wsel_q == rs_id);
   assign rt_idex_hit  = idex_valid_q && (idex_wsel_q != '0) && dec_uses_rt &&
                         (idex_wsel_q == rt_id);
   assign rs_exmem_hit = exmem_valid_q && (exmem_wsel_q != '0) && (exmem_wsel_q == rs_id);
   assign rt_exmem_hit = exmem_valid_q && (exmem_wsel_q != '0) && dec_uses_rt &&
                         (exmem_wsel_q == rt_id);

   assign pipe_adv = ihit &&
                     !(exmem_valid_q && (exmem_memread_q || exmem_memwrite_q) && !dhit);

`ifdef HAZARD_FORWARD_EN
   assign hazard = idex_memread_q && (rs_idex_hit || rt_idex_hit);
`else
   assign hazard = (idex_regwen_q && (rs_idex_hit || rt_idex_hit)) ||
                   (exmem_regwen_q && (rs_exmem_hit || rt_exmem_hit));
`endif

   // Branch flush wins over a load-use stall; all controls are quiet while in reset.
   assign ifid_flush  = nRST && branch_taken;
   assign hz_stall    = nRST && hazard && !branch_taken;
   assign idex_bubble = ifid_flush || hz_stall;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         idex_valid_q     <= 1'b0;
         idex_regwen_q    <= 1'b0;
         idex_memread_q   <= 1'b0;
         idex_memwrite_q  <= 1'b0;
         idex_wsel_q      <= '0;
         exmem_valid_q    <= 1'b0;
         exmem_regwen_q   <= 1'b0;
         exmem_memread_q  <= 1'b0;
         exmem_memwrite_q <= 1'b0;
         exmem_wsel_q     <= '0;
         memwb_valid_q    <= 1'b0;
         memwb_regwen_q   <= 1'b0;
         memwb_wsel_q     <= '0;
      end else if (pipe_adv) begin
         memwb_valid_q    <= exmem_valid_q;
         memwb_regwen_q   <= exmem_regwen_q;
         memwb_wsel_q     <= exmem_wsel_q;
         exmem_valid_q    <= idex_valid_q;
         exmem_regwen_q   <= idex_regwen_q;
         exmem_memread_q  <= idex_memread_q;
         exmem_memwrite_q <= idex_memwrite_q;
         exmem_wsel_q     <= idex_wsel_q;
         if (idex_bubble) begin
            idex_valid_q    <= 1'b0;
            idex_regwen_q   <= 1'b0;
            idex_memread_q  <= 1'b0;
            idex_memwrite_q <= 1'b0;
            idex_wsel_q     <= '0;
         end else begin
            idex_valid_q    <= 1'b1;
            idex_regwen_q   <= dec_regwen;
            idex_memread_q  <= dec_memread;
            idex_memwrite_q <= dec_memwrite;
            idex_wsel_q     <= dec_wsel;
         end
      end
   end

`ifdef HAZARD_FORWARD_EN
   logic [1:0] forwarda_d, forwardb_d;
   logic [1:0] forwarda_q, forwardb_q;

   // MEM/WB matches are left to register-file write-through, so they select 00.
   always_comb begin
      forwarda_d = 2'b00;
      forwardb_d = 2'b00;
      if (idex_regwen_q && rs_idex_hit)        forwarda_d = 2'b01;
      else if (exmem_regwen_q && rs_exmem_hit) forwarda_d = 2'b10;
      if (idex_regwen_q && rt_idex_hit)        forwardb_d = 2'b01;
      else if (exmem_regwen_q && rt_exmem_hit) forwardb_d = 2'b10;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         forwarda_q <= 2'b00;
         forwardb_q <= 2'b00;
      end else if (pipe_adv) begin
         forwarda_q <= idex_bubble ? 2'b00 : forwarda_d;
         forwardb_q <= idex_bubble ? 2'b00 : forwardb_d;
      end
   end

   assign forwarda = forwarda_q;
   assign forwardb = forwardb_q;
`else
   assign forwarda = 2'b00;
   assign forwardb = 2'b00;
`endif

   // MEM/WB is tracked for completeness; nothing in this block consumes it.
   logic unused_memwb;
   assign unused_memwb = ^{memwb_valid_q, memwb_regwen_q, memwb_wsel_q};

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Table-driven bench for hazard_forward_ctrl; expectations follow HAZARD_FORWARD_EN.
module tb_hazard_forward_ctrl;

   logic       CLK = 1'b0;
   logic       nRST;
   logic       ihit, dhit;
   logic [4:0] rs_id, rt_id, dec_wsel;
   logic       dec_uses_rt, dec_regwen, dec_memread, dec_memwrite, branch_taken;
   logic [1:0] forwarda, forwardb;
   logic       pipe_adv, hz_stall, ifid_flush, idex_bubble;

   int checks = 0;
   int errors = 0;

   hazard_forward_ctrl #(.REG_AW(5)) dut (
      .CLK          (CLK),
      .nRST         (nRST),
      .ihit         (ihit),
      .dhit         (dhit),
      .rs_id        (rs_id),
      .rt_id        (rt_id),
      .dec_uses_rt  (dec_uses_rt),
      .dec_regwen   (dec_regwen),
      .dec_memread  (dec_memread),
      .dec_memwrite (dec_memwrite),
      .dec_wsel     (dec_wsel),
      .branch_taken (branch_taken),
      .forwarda     (forwarda),
      .forwardb     (forwardb),
      .pipe_adv     (pipe_adv),
      .hz_stall     (hz_stall),
      .ifid_flush   (ifid_flush),
      .idex_bubble  (idex_bubble)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic       ihit, dhit, br;
      logic [4:0] rs, rt;
      logic       uses_rt, regwen, memread, memwrite;
      logic [4:0] wsel;
      logic [3:0] exp_ctl;   // {pipe_adv, hz_stall, ifid_flush, idex_bubble}
      logic [1:0] exp_fa, exp_fb;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t ins(input int rs, input int rt, input int u, input int rw,
                                input int mr, input int w, input int dh, input int br);
      vec_t v;
      v          = '0;
      v.ihit     = 1'b1;
      v.dhit     = dh[0];
      v.br       = br[0];
      v.rs       = rs[4:0];
      v.rt       = rt[4:0];
      v.uses_rt  = u[0];
      v.regwen   = rw[0];
      v.memread  = mr[0];
      v.wsel     = w[4:0];
      return v;
   endfunction

   task automatic push(input vec_t v, input logic [3:0] ctl, input logic [1:0] fa,
                       input logic [1:0] fb);
      v.exp_ctl = ctl;
      v.exp_fa  = fa;
      v.exp_fb  = fb;
      vq.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      ihit = v.ihit;  dhit = v.dhit;  branch_taken = v.br;
      rs_id = v.rs;   rt_id = v.rt;   dec_uses_rt = v.uses_rt;
      dec_regwen = v.regwen;  dec_memread = v.memread;  dec_memwrite = v.memwrite;
      dec_wsel = v.wsel;
   endtask

   task automatic chk(input string nm, input int idx, input logic [3:0] act,
                      input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %b expected %b", nm, idx, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input int idx, input logic [3:0] ctl,
                          input logic [1:0] fa, input logic [1:0] fb);
      chk({nm, " ctl"}, idx, {pipe_adv, hz_stall, ifid_flush, idex_bubble}, ctl);
      chk({nm, " fa"}, idx, {2'b00, forwarda}, {2'b00, fa});
      chk({nm, " fb"}, idx, {2'b00, forwardb}, {2'b00, fb});
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t nop;
      vec_t v;
      nop = ins(0, 0, 0, 0, 0, 0, 1, 0);

`ifdef HAZARD_FORWARD_EN
      push(ins(1, 2, 1, 1, 0, 3, 1, 0),  4'b1000, 2'b00, 2'b00); // add r3
      push(ins(3, 1, 1, 1, 0, 4, 1, 0),  4'b1000, 2'b00, 2'b00); // sub r4, rs=r3
      push(nop,                          4'b1000, 2'b01, 2'b00);
      push(nop,                          4'b1000, 2'b00, 2'b00);
      push(ins(1, 2, 1, 1, 0, 5, 1, 0),  4'b1000, 2'b00, 2'b00); // add r5
      push(nop,                          4'b1000, 2'b00, 2'b00);
      push(ins(1, 5, 1, 1, 0, 7, 1, 0),  4'b1000, 2'b00, 2'b00); // or, rt=r5
      push(nop,                          4'b1000, 2'b00, 2'b10);
      push(nop,                          4'b1000, 2'b00, 2'b00);
      push(ins(1, 0, 0, 1, 1, 2, 1, 0),  4'b1000, 2'b00, 2'b00); // lw r2
      push(ins(2, 0, 1, 1, 0, 6, 1, 0),  4'b1101, 2'b00, 2'b00); // add r6 load-use
      push(ins(2, 0, 1, 1, 0, 6, 1, 0),  4'b1000, 2'b00, 2'b00);
      push(nop,                          4'b1000, 2'b10, 2'b00);
      push(nop,                          4'b1000, 2'b00, 2'b00);
      push(ins(1, 2, 1, 1, 0, 8, 1, 0),  4'b1000, 2'b00, 2'b00); // add r8
      push(ins(8, 0, 0, 1, 1, 9, 1, 0),  4'b1000, 2'b00, 2'b00); // lw r9, rs=r8
      push(ins(8, 0, 0, 1, 0, 10, 1, 0), 4'b1000, 2'b01, 2'b00); // or r10, rs=r8
      push(ins(10, 9, 1, 1, 0, 11, 0, 0), 4'b0000, 2'b10, 2'b00); // dhit low x3
      push(ins(10, 9, 1, 1, 0, 11, 0, 0), 4'b0000, 2'b10, 2'b00);
      push(ins(10, 9, 1, 1, 0, 11, 0, 0), 4'b0000, 2'b10, 2'b00);
      push(ins(10, 9, 1, 1, 0, 11, 1, 0), 4'b1000, 2'b10, 2'b00);
      push(nop,                          4'b1000, 2'b01, 2'b10);
      push(nop,                          4'b1000, 2'b00, 2'b00);
      push(ins(1, 0, 0, 1, 1, 2, 1, 0),  4'b1000, 2'b00, 2'b00); // lw r2
      push(ins(2, 0, 1, 1, 0, 6, 1, 1),  4'b1011, 2'b00, 2'b00); // branch + load-use
      push(nop,                          4'b1000, 2'b00, 2'b00);
      push(nop,                          4'b1000, 2'b00, 2'b00);
      push(ins(1, 2, 1, 1, 0, 0, 1, 0),  4'b1000, 2'b00, 2'b00); // add r0
      push(ins(0, 0, 1, 1, 0, 12, 1, 0), 4'b1000, 2'b00, 2'b00); // reader of r0
      push(ins(1, 0, 0, 1, 1, 0, 1, 0),  4'b1000, 2'b00, 2'b00); // lw r0
      push(ins(0, 0, 1, 1, 0, 13, 1, 0), 4'b1000, 2'b00, 2'b00);
      push(nop,                          4'b1000, 2'b00, 2'b00);
`else
      push(ins(1, 2, 1, 1, 0, 3, 1, 0),  4'b1000, 2'b00, 2'b00); // add r3
      push(ins(3, 1, 1, 1, 0, 4, 1, 0),  4'b1101, 2'b00, 2'b00); // sub r4 stalls
      push(ins(3, 1, 1, 1, 0, 4, 1, 0),  4'b1101, 2'b00, 2'b00);
      push(ins(3, 1, 1, 1, 0, 4, 1, 0),  4'b1000, 2'b00, 2'b00);
      push(nop,                          4'b1000, 2'b00, 2'b00);
      push(nop,                          4'b1000, 2'b00, 2'b00);
      push(ins(1, 2, 1, 1, 0, 5, 1, 0),  4'b1000, 2'b00, 2'b00); // add r5
      push(nop,                          4'b1000, 2'b00, 2'b00);
      push(ins(1, 5, 1, 1, 0, 7, 1, 0),  4'b1101, 2'b00, 2'b00); // or: one stall
      push(ins(1, 5, 1, 1, 0, 7, 1, 0),  4'b1000, 2'b00, 2'b00);
      push(nop,                          4'b1000, 2'b00, 2'b00);
      push(nop,                          4'b1000, 2'b00, 2'b00);
      push(ins(1, 0, 0, 1, 1, 2, 1, 0),  4'b1000, 2'b00, 2'b00); // lw r2
      push(ins(2, 0, 1, 1, 0, 6, 1, 0),  4'b1101, 2'b00, 2'b00);
      push(ins(2, 0, 1, 1, 0, 6, 1, 0),  4'b1101, 2'b00, 2'b00);
      push(ins(2, 0, 1, 1, 0, 6, 1, 0),  4'b1000, 2'b00, 2'b00);
      push(nop,                          4'b1000, 2'b00, 2'b00);
      push(nop,                          4'b1000, 2'b00, 2'b00);
      push(ins(1, 0, 0, 1, 1, 9, 1, 0),  4'b1000, 2'b00, 2'b00); // lw r9
      push(nop,                          4'b1000, 2'b00, 2'b00);
      push(ins(9, 0, 0, 1, 0, 11, 0, 0), 4'b0101, 2'b00, 2'b00); // dhit low x3
      push(ins(9, 0, 0, 1, 0, 11, 0, 0), 4'b0101, 2'b00, 2'b00);
      push(ins(9, 0, 0, 1, 0, 11, 0, 0), 4'b0101, 2'b00, 2'b00);
      push(ins(9, 0, 0, 1, 0, 11, 1, 0), 4'b1101, 2'b00, 2'b00);
      push(ins(9, 0, 0, 1, 0, 11, 1, 0), 4'b1000, 2'b00, 2'b00);
      push(nop,                          4'b1000, 2'b00, 2'b00);
      push(nop,                          4'b1000, 2'b00, 2'b00);
      push(ins(1, 0, 0, 1, 1, 2, 1, 0),  4'b1000, 2'b00, 2'b00); // lw r2
      push(ins(2, 0, 1, 1, 0, 6, 1, 1),  4'b1011, 2'b00, 2'b00); // branch + load-use
      push(nop,                          4'b1000, 2'b00, 2'b00);
      push(nop,                          4'b1000, 2'b00, 2'b00);
      push(ins(1, 2, 1, 1, 0, 0, 1, 0),  4'b1000, 2'b00, 2'b00); // add r0
      push(ins(0, 0, 1, 1, 0, 12, 1, 0), 4'b1000, 2'b00, 2'b00);
      push(nop,                          4'b1000, 2'b00, 2'b00);
      push(ins(1, 0, 0, 1, 1, 0, 1, 0),  4'b1000, 2'b00, 2'b00); // lw r0
      push(ins(0, 0, 1, 1, 0, 13, 1, 0), 4'b1000, 2'b00, 2'b00);
      push(nop,                          4'b1000, 2'b00, 2'b00);
`endif

      // Reset state: controls quiet even with branch_taken high, pipe_adv follows ihit.
      nRST = 1'b0;
      drive(nop);
      branch_taken = 1'b1;
      #2;
      chk_all("reset ihit1", 0, 4'b1000, 2'b00, 2'b00);
      ihit = 1'b0;
      #1;
      chk_all("reset ihit0", 0, 4'b0000, 2'b00, 2'b00);
      @(negedge CLK);
      nRST = 1'b1;
      drive(nop);

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge CLK);
         drive(vq[i]);
         #2;
         chk_all("vec", i, vq[i].exp_ctl, vq[i].exp_fa, vq[i].exp_fb);
      end

      // Reset pulsed in the middle of a load-use stall.
      @(negedge CLK);
      drive(ins(1, 0, 0, 1, 1, 2, 1, 0));
      @(negedge CLK);
      v = ins(2, 0, 1, 1, 0, 6, 1, 0);
      drive(v);
      #2;
      chk("midstall pre ctl", 0, {pipe_adv, hz_stall, ifid_flush, idex_bubble}, 4'b1101);
      nRST = 1'b0;
      branch_taken = 1'b1;
      #1;
      chk_all("midstall rst", 0, 4'b1000, 2'b00, 2'b00);
      @(negedge CLK);
      nRST = 1'b1;
      drive(v);
      #2;
      chk_all("midstall post", 0, 4'b1000, 2'b00, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
